vga_box_renderer: RTL and testbench
===================================

# vga_box_renderer

Pixel-generation stage that sits directly downstream of the VGA timing generator. It consumes the generator's counters, sync and display-enable signals and draws a solid square that bounces around the 640x480 active area, moving once per frame. It drives 4-bit R/G/B outputs plus re-timed hsync/vsync to the VGA connector. The box colour steps through a 4-entry palette on every bounce.

## Interface
- BOX_SIZE, 32: box edge length in pixels (1..479).
- STEP, 2: pixels moved per frame on each axis (1..BOX_SIZE).
- BG, 12'h000: background RGB for active pixels outside the box.

- clk  in  1  pixel clock (25 MHz); the same clock as the timing generator.
- reset  in  1  asynchronous, active-high reset.
- hcount  in  10  horizontal count, 0..799.
- vcount  in  10  vertical count, 0..524.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- hdisp  in  1  horizontal active flag (hcount 144..783).
- vdisp  in  1  vertical active flag (vcount 35..514).
- pause  in  1  when high, freezes position, direction and colour.
- hsync  out  1  hsync_in delayed 1 cycle.
- vsync  out  1  vsync_in delayed 1 cycle.
- red, green, blue  out  4 each  pixel colour.
- frame_tick  out  1  one-cycle pulse, registered, marking each frame update.

## Operation
- Pixel coordinates: x = hcount − 144 and y = vcount − 35, both 10-bit. They are meaningful only when hdisp & vdisp.
- State registers:
  - box_x, 10 bits, range 0..XMAX, where XMAX = 640 − BOX_SIZE.
  - box_y, 10 bits, range 0..YMAX, where YMAX = 480 − BOX_SIZE.
  - dx, dy: 1 = increasing.
  - cidx, 2 bits.
- Reset values: box_x = 0, box_y = 0, dx = 1, dy = 1, cidx = 0.
- Frame event: hcount == 799 && vcount == 524, with pause low. The position updates on that clock edge, so the new position applies from the next frame's first active pixel.
- X update on each frame event:
  - dx = 1: if box_x + STEP ≥ XMAX, then box_x ← XMAX and dx ← 0; otherwise box_x ← box_x + STEP.
  - dx = 0: if box_x ≤ STEP, then box_x ← 0 and dx ← 1; otherwise box_x ← box_x − STEP.
- Y update follows the same rules, using YMAX and dy.
- Bounce: any axis reversal in a frame event. cidx ← cidx + 1, wrapping mod 4. When both axes reverse in the same event, cidx still increments by exactly 1.
- Palette: 0 = F00, 1 = 0F0, 2 = 00F, 3 = FFF.
- Pixel select, from the combinational inputs of the current cycle:
  - !(hdisp & vdisp): RGB = 000. This is required blanking.
  - Otherwise, if box_x ≤ x < box_x + BOX_SIZE and box_y ≤ y < box_y + BOX_SIZE: RGB = palette[cidx].
  - Otherwise: RGB = BG.
- Comparisons are done at 11-bit width so that box_x + BOX_SIZE cannot overflow.
- pause high: the frame event is suppressed. Rendering continues at the frozen position, and frame_tick stays low.

## Timing
- Latency is 1 clock. red/green/blue, hsync and vsync are all registered in the same stage, so colour stays aligned with sync at the connector.
- Reset values of the outputs: hsync = 1, vsync = 1, red/green/blue = 0, frame_tick = 0.
- frame_tick is high in the cycle after the edge on which the frame event occurs. It is high for exactly one cycle per un-paused frame.
- Reset asserted mid-frame:
  - All state and outputs go to their reset values immediately (asynchronously).
  - After deassertion, rendering resumes at box (0,0) from the current counter position.
  - No frame event occurs until the next hcount == 799 && vcount == 524.
- pause changing state: pause is sampled only in the frame-event cycle, so a change mid-frame never tears the image.

## Test plan
- **Reset and first frame.** Hold reset, release it, then run the timing generator.
  - hcount 144..175 with vcount 35..66: RGB = F00, seen 1 cycle later.
  - hcount 176 (active area): RGB = BG.
  - hcount 0..143 and hcount 784..799: RGB = 000.
  - hsync/vsync equal the inputs delayed by 1 cycle.
- **Single step.** After 1 frame event: box_x = 2, box_y = 2, and frame_tick is a single pulse. Red now appears at hcount 146..177, vcount 37..68.
- **Y bounce.** Run 224 frame events. box_y = 448, dy = 0, cidx = 1, so the box is green. On the next event box_y = 446.
- **X bounce.** Run 304 frame events. box_x = 608, dx = 0, cidx = 2, so the box is blue. The right box edge lands at hcount 783 and does not wrap.
- **Pause.** Assert pause across 3 frame boundaries. box_x, box_y and cidx are unchanged, and frame_tick stays 0. Deassert pause: the next event moves the box by STEP.
- **Mid-frame reset.** Pulse reset at vcount 200 with the box at (100,100).
  - All outputs go to 0 and hsync/vsync to 1 in the same cycle.
  - The rest of that frame draws the box at (0,0) wherever in-box rows remain.

Source files
------------

// File: rtl/vga_box_renderer.sv
// Pixel stage behind the VGA timing generator: draws a solid square that bounces
// around the 640x480 active area, advancing once per frame, with colour/sync re-timed together.
module vga_box_renderer #(
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter logic [11:0] BG       = 12'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hdisp,
    input  logic       vdisp,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick
);

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] XMAX   = CW'(640 - BOX_SIZE);
    localparam logic [CW-1:0] YMAX   = CW'(480 - BOX_SIZE);
    localparam logic [CW-1:0] STEP_W = CW'(STEP);
    localparam logic [CW-1:0] SIZE_W = CW'(BOX_SIZE);
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] H_START = 10'd144;
    localparam logic [9:0] V_START = 10'd35;

    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        dx_q, dx_d;
    logic        dy_q, dy_d;
    logic [1:0]  cidx_q, cidx_d;
    logic        hsync_q, vsync_q, tick_q, tick_d;
    logic [11:0] rgb_q, rgb_d;

    logic            frame_ev_c;
    logic [CW-1:0]   bx_w, by_w, px_w, py_w, nx_w, ny_w;
    logic            ndx_c, ndy_c, in_box_c;
    logic [9:0]      x_c, y_c;
    logic [11:0]     pal_c;

    // One axis of the bounce: returns {new_dir, new_pos}; reversal clamps to the wall.
    function automatic logic [CW:0] axis_next(input logic [CW-1:0] pos, input logic dir,
                                              input logic [CW-1:0] maxv);
        logic [CW:0] r;
        if (dir) begin
            if (pos + STEP_W >= maxv) r = {1'b0, maxv};
            else                      r = {1'b1, pos + STEP_W};
        end else begin
            if (pos <= STEP_W)        r = {1'b1, CW'(0)};
            else                      r = {1'b0, pos - STEP_W};
        end
        return r;
    endfunction

    always_comb begin
        frame_ev_c = (hcount == H_LAST) && (vcount == V_LAST) && !pause;
        bx_w = {1'b0, box_x_q};
        by_w = {1'b0, box_y_q};
        {ndx_c, nx_w} = axis_next(bx_w, dx_q, XMAX);
        {ndy_c, ny_w} = axis_next(by_w, dy_q, YMAX);

        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cidx_d  = cidx_q;
        tick_d  = frame_ev_c;
        if (frame_ev_c) begin
            box_x_d = 10'(nx_w);
            box_y_d = 10'(ny_w);
            dx_d    = ndx_c;
            dy_d    = ndy_c;
            // A double-axis bounce still advances the palette only once.
            cidx_d  = cidx_q + 2'((ndx_c != dx_q) || (ndy_c != dy_q));
        end
    end

    always_comb begin
        x_c  = hcount - H_START;
        y_c  = vcount - V_START;
        px_w = {1'b0, x_c};
        py_w = {1'b0, y_c};
        in_box_c = (px_w >= bx_w) && (px_w < bx_w + SIZE_W) &&
                   (py_w >= by_w) && (py_w < by_w + SIZE_W);
        case (cidx_q)
            2'd0:    pal_c = 12'hF00;
            2'd1:    pal_c = 12'h0F0;
            2'd2:    pal_c = 12'h00F;
            default: pal_c = 12'hFFF;
        endcase
        rgb_d = BG;
        if (!(hdisp && vdisp)) rgb_d = 12'h000;
        else if (in_box_c)     rgb_d = pal_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x_q <= 10'd0;
            box_y_q <= 10'd0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            cidx_q  <= 2'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cidx_q  <= cidx_d;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
            tick_q  <= tick_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: drives counters directly (no full-frame scan), scoreboards
// every output cycle against a behavioural model and checks fixed pixel tables.
module tb_vga_box_renderer;

    localparam int BOX  = 32;
    localparam int STEP = 2;
    localparam int XMAX = 640 - BOX;
    localparam int YMAX = 480 - BOX;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount;
    logic       hsync_in, vsync_in, hdisp, vdisp, pause;
    logic       hsync, vsync, frame_tick;
    logic [3:0] red, green, blue;

    vga_box_renderer dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hdisp(hdisp), .vdisp(vdisp),
        .pause(pause), .hsync(hsync), .vsync(vsync), .red(red), .green(green),
        .blue(blue), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        ft;
    } out_t;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] rgb;
    } vec_t;

    out_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          m_bx, m_by, m_dx, m_dy, m_ci;
    logic [11:0] last_rgb;

    function automatic logic [11:0] pal(input int i);
        case (i)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic logic [11:0] model_rgb(input int h, input int v);
        int x, y;
        if (!(h >= 144 && h <= 783 && v >= 35 && v <= 514)) return 12'h000;
        x = h - 144;
        y = v - 35;
        if (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) return pal(m_ci);
        return 12'h000;
    endfunction

    task automatic model_event();
        bit rev = 0;
        if (m_dx == 1) begin
            if (m_bx + STEP >= XMAX) begin m_bx = XMAX; m_dx = 0; rev = 1; end
            else m_bx = m_bx + STEP;
        end else begin
            if (m_bx <= STEP) begin m_bx = 0; m_dx = 1; rev = 1; end
            else m_bx = m_bx - STEP;
        end
        if (m_dy == 1) begin
            if (m_by + STEP >= YMAX) begin m_by = YMAX; m_dy = 0; rev = 1; end
            else m_by = m_by + STEP;
        end else begin
            if (m_by <= STEP) begin m_by = 0; m_dy = 1; rev = 1; end
            else m_by = m_by - STEP;
        end
        if (rev) m_ci = (m_ci + 1) % 4;
    endtask

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_ci = 0;
    endtask

    // Drive one cycle of generator inputs, push the model's expectation, compare after the edge.
    task automatic apply(input int h, input int v, input logic p);
        out_t e, a;
        logic hs, vs;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        hcount = 10'(h); vcount = 10'(v);
        hdisp = (h >= 144 && h <= 783);
        vdisp = (v >= 35 && v <= 514);
        hsync_in = hs; vsync_in = vs; pause = p;
        e.rgb = model_rgb(h, v);
        e.hs  = hs;
        e.vs  = vs;
        e.ft  = (h == 799 && v == 524 && !p);
        exp_q.push_back(e);
        if (e.ft) model_event();
        @(posedge clk);
        #1;
        a = {red, green, blue, hsync, vsync, frame_tick};
        e = exp_q.pop_front();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL cycle h=%0d v=%0d p=%b: got rgb=%h hs=%b vs=%b ft=%b, want rgb=%h hs=%b vs=%b ft=%b",
                     h, v, p, a.rgb, a.hs, a.vs, a.ft, e.rgb, e.hs, e.vs, e.ft);
        end
        last_rgb = a.rgb;
        @(negedge clk);
    endtask

    task automatic check_rgb(input string name, input int h, input int v, input logic [11:0] want);
        apply(h, v, 1'b0);
        n_vec++;
        if (last_rgb !== want) begin
            n_bad++;
            $display("FAIL %s h=%0d v=%0d: got rgb=%h want %h", name, h, v, last_rgb, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({red, green, blue, hsync, vsync, frame_tick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b ft=%b want rgb=000 hs=1 vs=1 ft=0",
                     name, {red, green, blue}, hsync, vsync, frame_tick);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // n frame events, each followed by a random pixel and one near the box edges.
    task automatic frames(input int n);
        repeat (n) begin
            apply(799, 524, 1'b0);
            apply(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b0);
            apply(143 + m_bx + int'($urandom_range(0, 33)), 34 + m_by + int'($urandom_range(0, 33)), 1'b0);
        end
    endtask

    vec_t first_tbl[] = '{
        '{144, 35, 12'hF00}, '{175, 66, 12'hF00}, '{160, 50, 12'hF00}, '{176, 35, 12'h000},
        '{175, 67, 12'h000}, '{0, 40, 12'h000},   '{143, 40, 12'h000}, '{784, 40, 12'h000},
        '{799, 40, 12'h000}, '{150, 20, 12'h000}
    };
    vec_t step_tbl[] = '{
        '{146, 37, 12'hF00}, '{177, 68, 12'hF00}, '{145, 37, 12'h000}, '{178, 68, 12'h000},
        '{146, 36, 12'h000}, '{146, 69, 12'h000}
    };

    initial begin
        reset = 1'b1;
        hcount = '0; vcount = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        hdisp = 1'b0; vdisp = 1'b0; pause = 1'b0;
        do_reset();

        foreach (first_tbl[i]) check_rgb("first_frame", first_tbl[i].h, first_tbl[i].v, first_tbl[i].rgb);

        apply(799, 524, 1'b0);
        apply(10, 10, 1'b0);
        foreach (step_tbl[i]) check_rgb("single_step", step_tbl[i].h, step_tbl[i].v, step_tbl[i].rgb);

        // Pause across three frame boundaries, with mid-frame pause toggles between them.
        repeat (3) begin
            apply(799, 524, 1'b1);
            apply(150, 40, 1'b1);
            apply(300, 300, 1'b0);
        end
        check_rgb("pause_hold", 146, 37, 12'hF00);
        apply(799, 524, 1'b0);
        check_rgb("pause_resume_in", 148, 39, 12'hF00);
        check_rgb("pause_resume_out", 147, 39, 12'h000);

        frames(222);
        check_rgb("ybounce_top", 592, 483, 12'h0F0);
        check_rgb("ybounce_above", 592, 482, 12'h000);
        check_rgb("ybounce_last_row", 623, 514, 12'h0F0);
        check_rgb("ybounce_right", 624, 514, 12'h000);
        frames(1);
        check_rgb("ybounce_back", 594, 481, 12'h0F0);
        check_rgb("ybounce_back_left", 593, 481, 12'h000);

        frames(79);
        check_rgb("xbounce_right_edge", 783, 323, 12'h00F);
        check_rgb("xbounce_left_edge", 752, 323, 12'h00F);
        check_rgb("xbounce_outside", 751, 323, 12'h000);
        check_rgb("xbounce_hblank", 784, 323, 12'h000);
        check_rgb("xbounce_no_wrap", 144, 323, 12'h000);
        frames(20);

        do_reset();
        frames(50);
        check_rgb("pre_reset_box", 250, 140, 12'hF00);
        hcount = 10'd250; vcount = 10'd200;
        #2 reset = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_rgb("after_reset_row", 150, 210, 12'h000);
        apply(799, 300, 1'b0);
        check_rgb("after_reset_box00", 150, 40, 12'hF00);
        apply(799, 524, 1'b0);
        check_rgb("after_reset_step", 146, 37, 12'hF00);
        check_rgb("after_reset_step_out", 145, 37, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
